sig_lut_interp: RTL
===================

Name: sig_lut_interp

Overview:
- Pipelined consumer of the per-gate sigmoid LUT in the LSTM datapath: drives the LUT address, reads back the base and next entries, and linearly interpolates between them to produce sigmoid(x).
- Sits between the layer accumulator output and the gate multiply stage.
- Uses a valid/ready handshake on both sides and stalls the whole pipeline under backpressure.

Parameters:
- DATA_W, 8, width of the signed input x and of the LUT entries and result y.
- ADDR_W, 4, LUT address width; equals the upper ADDR_W bits of x.
- FRAC_W, 4, fraction width; equals the lower FRAC_W bits of x. ADDR_W+FRAC_W must equal DATA_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  x is valid this cycle.
- in_ready  out  1  block accepts x this cycle.
- in_x  in  DATA_W  signed input, two's complement.
- lut_address  out  ADDR_W  address driven to the LUT.
- lut_base  in  DATA_W  signed LUT entry at lut_address (combinational return).
- lut_next  in  DATA_W  signed next LUT entry (combinational return; LUT applies its own wrap/saturation).
- out_valid  out  1  y is valid.
- out_ready  in  1  downstream accepts y.
- out_y  out  DATA_W  signed interpolated sigmoid.

Behaviour:
- Reset (asynchronous, active-high): all stage-valid flags clear, all data registers clear, out_valid=0, out_y=0, lut_address=0. A reset asserted mid-operation discards all in-flight samples; nothing is emitted afterwards for them.
- Stall: stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stall=1, every pipeline register (data and valid) holds its value.
- Stage S0:
  - On in_valid & in_ready, register addr = in_x[DATA_W-1:FRAC_W], frac = in_x[FRAC_W-1:0] (unsigned), and v0=1.
  - Otherwise, when not stalled, v0=0.
  - lut_address is driven from the S0 addr register.
- Stage S1: when not stalled, capture lut_base, lut_next, frac and v1=v0.
- Stage S2: when not stalled, compute out_y and set out_valid=v1.
- Latency: exactly 3 cycles from the in handshake to out_valid with no stall. Throughput is 1 sample/cycle.
- Arithmetic (all in S2):
  - diff = next - base, sign-extended to DATA_W+1 bits.
  - prod = diff * {0,frac}, signed, DATA_W+FRAC_W+2 bits.
  - y = base + (prod >>> FRAC_W), arithmetic shift (floor toward -inf).
  - Saturate y to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Address semantics: addresses 0..7 correspond to x>=0 and 8..15 to x<0. The block passes addr straight through. Continuity across the zero crossing (addr 15 -> next=entry 0) and positive saturation (addr 7 -> next=entry 7) are supplied by the LUT; the block applies no special case.
- Boundary conditions:
  - A new sample accepted in the same cycle the output handshake completes advances normally (no bubble).
  - in_valid while stalled is not accepted; the source holds in_x.
  - out_y is stable while out_valid & ~out_ready.

Test Plan:
- LUT model 8,11,14,15,15,15,15,15,0,0,0,0,0,0,1,4; x=0x00 -> out_y=8 three cycles later; x=0x08 -> 9.
- Zero-crossing wrap: x=0xF8 (addr15, frac8, base4, next8) -> 6; x=0xE8 -> 2; x=0x88 -> 0.
- Saturation end: x=0x7F (addr7, base=next=15) -> 15; x=0x70 -> 15.
- Back-to-back stream 0x00,0x08,0xF8,0x7F with out_ready=1 -> 8,9,6,15 on consecutive cycles, in_ready stays 1.
- Backpressure: hold out_ready=0 for 4 cycles mid-stream -> out_y held, in_ready=0, no sample lost or duplicated, order preserved after release.
- Reset mid-stream with 3 samples in flight -> out_valid=0 immediately (asynchronously). No output for those samples; the first post-reset sample appears at 3-cycle latency.

Source files
------------

// File: rtl/sig_lut_interp.sv
// sig_lut_interp: three-stage sigmoid LUT interpolator for the LSTM gate path.
//   S0 registers the LUT address (upper bits of x) and the fraction (lower bits).
//   S1 captures the combinational LUT return (base, next) alongside the fraction.
//   S2 computes y = base + floor((next - base) * frac / 2^FRAC_W), saturated.
// Ports:
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready  input handshake, in_x is the signed sample
//   lut_address        address to the external LUT (from the S0 register)
//   lut_base/lut_next  signed LUT entries at lut_address and the following slot
//   out_valid/out_ready output handshake, out_y is the signed result
// Whole pipeline stalls while out_valid & ~out_ready.
module sig_lut_interp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    output logic [ADDR_W-1:0] lut_address,
    input  logic [DATA_W-1:0] lut_base,
    input  logic [DATA_W-1:0] lut_next,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y
);

    localparam int unsigned ProdW = DATA_W + FRAC_W + 2;

    logic stall;

    // S0
    logic [ADDR_W-1:0] addr_q;
    logic [FRAC_W-1:0] frac0_q;
    logic              v0_q;

    // S1
    logic [DATA_W-1:0] base_q;
    logic [DATA_W-1:0] next_q;
    logic [FRAC_W-1:0] frac1_q;
    logic              v1_q;

    // S2 arithmetic
    logic signed [DATA_W:0]    diff;
    logic signed [ProdW-1:0]   diff_ext;
    logic signed [ProdW-1:0]   frac_ext;
    logic signed [ProdW-1:0]   prod;
    logic signed [ProdW-1:0]   sum;
    logic        [DATA_W-1:0]  y_sat;

    assign stall       = out_valid & ~out_ready;
    assign in_ready    = ~stall;
    assign lut_address = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            frac0_q <= '0;
            v0_q    <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                addr_q  <= in_x[DATA_W-1:FRAC_W];
                frac0_q <= in_x[FRAC_W-1:0];
                v0_q    <= 1'b1;
            end else begin
                v0_q    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            next_q  <= '0;
            frac1_q <= '0;
            v1_q    <= 1'b0;
        end else if (!stall) begin
            base_q  <= lut_base;
            next_q  <= lut_next;
            frac1_q <= frac0_q;
            v1_q    <= v0_q;
        end
    end

    always_comb begin
        diff     = $signed({next_q[DATA_W-1], next_q}) - $signed({base_q[DATA_W-1], base_q});
        diff_ext = $signed({{(ProdW-DATA_W-1){diff[DATA_W]}}, diff});
        // Fraction is unsigned: zero-extend so the multiply stays signed.
        frac_ext = $signed({{(ProdW-FRAC_W){1'b0}}, frac1_q});
        prod     = diff_ext * frac_ext;
        sum      = $signed({{(ProdW-DATA_W){base_q[DATA_W-1]}}, base_q}) + (prod >>> FRAC_W);
        // Overflow when the bits above the result sign are not a pure sign extension.
        if (sum[ProdW-1:DATA_W-1] != {(ProdW-DATA_W+1){sum[ProdW-1]}}) begin
            y_sat = sum[ProdW-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
        end else begin
            y_sat = sum[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_y     <= '0;
            out_valid <= 1'b0;
        end else if (!stall) begin
            out_y     <= y_sat;
            out_valid <= v1_q;
        end
    end

endmodule
